// File: rtl/jt12_wr_sched.sv
// Write scheduler: round-robin arbitration of two CPU write requesters into a FIFO,
// drained into the jt12 write port as single-cycle strobes that honour the busy flag.
module jt12_wr_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned GAP   = 2,
    parameter int unsigned TMO   = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          a_req,
    input  logic [1:0]    a_addr,
    input  logic [7:0]    a_din,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [1:0]    b_addr,
    input  logic [7:0]    b_din,
    output logic          b_ack,
    input  logic          ym_busy,
    output logic [1:0]    ym_addr,
    output logic [7:0]    ym_din,
    output logic          ym_cs_n,
    output logic          ym_wr_n,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   level,
    output logic          tmo_err
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = 8;
    localparam int unsigned HW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] din;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_full;
    logic            r_empty;
    logic            r_a_ack;
    logic            r_b_ack;
    logic            r_last_b;

    logic [1:0]      r_state;
    logic [HW-1:0]   r_hold;
    logic [TW-1:0]   r_tmo;
    logic            r_cs_n;
    logic            r_wr_n;
    logic [1:0]      r_ym_addr;
    logic [7:0]      r_ym_din;
    logic            r_tmo_err;

    logic            w_a_elig;
    logic            w_b_elig;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_tie;
    logic            w_push;
    logic            w_pop;
    entry_t          w_push_data;
    entry_t          w_head;
    logic [LW-1:0]   w_level_nxt;

    logic [1:0]      w_state_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [TW-1:0]   w_tmo_nxt;
    logic            w_cs_n_nxt;
    logic            w_wr_n_nxt;
    logic [1:0]      w_ym_addr_nxt;
    logic [7:0]      w_ym_din_nxt;
    logic            w_tmo_err_nxt;

    // A requester whose ack is already high is ineligible, so one request is never pushed twice
    always_comb begin
        w_a_elig  = a_req & ~r_a_ack;
        w_b_elig  = b_req & ~r_b_ack;
        w_tie     = w_a_elig & w_b_elig & ~r_full;
        w_grant_a = ~r_full & w_a_elig & (~w_b_elig | r_last_b);
        w_grant_b = ~r_full & w_b_elig & (~w_a_elig | ~r_last_b);
        w_push    = w_grant_a | w_grant_b;
        w_push_data.addr = w_grant_a ? a_addr : b_addr;
        w_push_data.din  = w_grant_a ? a_din  : b_din;
    end

    assign w_head = r_mem[r_rptr];

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_last_b <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            r_a_ack <= w_grant_a;
            r_b_ack <= w_grant_b;
            // Priority only flips on a genuine tie
            if (w_tie) begin
                r_last_b <= w_grant_b;
            end
        end
    end

    // Drain FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_tmo     <= '0;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ym_addr <= '0;
            r_ym_din  <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_tmo     <= w_tmo_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_ym_addr <= w_ym_addr_nxt;
            r_ym_din  <= w_ym_din_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_tmo_nxt     = r_tmo;
        w_cs_n_nxt    = 1'b1;
        w_wr_n_nxt    = 1'b1;
        w_ym_addr_nxt = r_ym_addr;
        w_ym_din_nxt  = r_ym_din;
        w_tmo_err_nxt = 1'b0;
        w_pop         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty && cen) begin
                    w_state_nxt   = S_ISSUE;
                    w_ym_addr_nxt = w_head.addr;
                    w_ym_din_nxt  = w_head.din;
                    w_cs_n_nxt    = 1'b0;
                    w_wr_n_nxt    = 1'b0;
                    w_pop         = 1'b1;
                end
            end
            S_ISSUE: begin
                // Only data writes (odd port address) make the chip busy
                if (r_ym_addr[0]) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = HW'(GAP - 1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_hold == '0) begin
                    w_state_nxt = S_WAIT;
                    w_tmo_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            S_WAIT: begin
                if (!ym_busy) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_tmo_nxt     = '0;
                    w_tmo_err_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign a_ack      = r_a_ack;
    assign b_ack      = r_b_ack;
    assign ym_addr    = r_ym_addr;
    assign ym_din     = r_ym_din;
    assign ym_cs_n    = r_cs_n;
    assign ym_wr_n    = r_wr_n;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign level      = r_level;
    assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Bench for jt12_wr_sched: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, FIFO order and write spacing.
module tb_jt12_wr_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned GAP   = 2;
    localparam int unsigned TMO   = 255;
    localparam int unsigned LW    = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b1;
    logic          a_req = 1'b0;
    logic [1:0]    a_addr = '0;
    logic [7:0]    a_din = '0;
    logic          b_req = 1'b0;
    logic [1:0]    b_addr = '0;
    logic [7:0]    b_din = '0;
    logic          ym_busy = 1'b0;
    logic          a_ack, b_ack, ym_cs_n, ym_wr_n, fifo_full, fifo_empty, tmo_err;
    logic [1:0]    ym_addr;
    logic [7:0]    ym_din;
    logic [AW:0]   level;

    jt12_wr_sched #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack),
        .ym_busy(ym_busy), .ym_addr(ym_addr), .ym_din(ym_din),
        .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model state: expected FIFO content, pending requester data, drain timing
    logic [9:0] q[$];
    logic [9:0] a_src[$];
    logic [9:0] b_src[$];
    logic [9:0] obs[$];
    int         obs_edge[$];
    bit         m_a_ack, m_b_ack, m_last_b, m_waiting;
    int         m_ready, m_wait_first, m_wait_cnt;
    bit         exp_cs, exp_tmo;
    logic [1:0] exp_addr;
    logic [7:0] exp_din;

    task automatic model_reset();
        q.delete();
        m_a_ack = 0; m_b_ack = 0; m_last_b = 1; m_waiting = 0;
        m_ready = 0; m_wait_cnt = 0; m_wait_first = 0;
        exp_cs = 1; exp_tmo = 0; exp_addr = '0; exp_din = '0;
    endtask

    // One clock edge of the reference: arbitration rules, then write-spacing rules
    task automatic model_edge();
        bit ea, eb, ga, gb, issue;
        int sz;
        logic [9:0] head;
        if (!rst_n) return;
        sz = q.size();
        ea = a_req && !m_a_ack;
        eb = b_req && !m_b_ack;
        ga = 0; gb = 0;
        if (sz < DEPTH) begin
            if (ea && eb) begin
                if (m_last_b) ga = 1; else gb = 1;
                m_last_b = gb;
            end else if (ea) ga = 1;
            else if (eb) gb = 1;
        end
        issue = 0;
        exp_tmo = 0;
        if (m_waiting) begin
            if (edge_n >= m_wait_first) begin
                if (!ym_busy) begin
                    m_waiting = 0; m_ready = edge_n + 1;
                end else begin
                    m_wait_cnt++;
                    if (m_wait_cnt == TMO) begin
                        exp_tmo = 1; m_waiting = 0; m_ready = edge_n + 1;
                    end
                end
            end
        end else if (edge_n >= m_ready && cen && sz > 0) begin
            head = q.pop_front();
            issue = 1;
            exp_addr = head[9:8];
            exp_din = head[7:0];
            if (head[8]) begin
                m_waiting = 1; m_wait_first = edge_n + 2 + GAP; m_wait_cnt = 0;
            end else begin
                m_ready = edge_n + 2;
            end
        end
        exp_cs = !issue;
        if (ga) begin q.push_back({a_addr, a_din}); void'(a_src.pop_front()); end
        if (gb) begin q.push_back({b_addr, b_din}); void'(b_src.pop_front()); end
        m_a_ack = ga;
        m_b_ack = gb;
    endtask

    task automatic drive();
        if (a_src.size() > 0) begin a_req = 1'b1; {a_addr, a_din} = a_src[0]; end
        else a_req = 1'b0;
        if (b_src.size() > 0) begin b_req = 1'b1; {b_addr, b_din} = b_src[0]; end
        else b_req = 1'b0;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        if (ym_cs_n === 1'b0) begin
            obs.push_back({ym_addr, ym_din});
            obs_edge.push_back(edge_n);
        end
    endtask

    task automatic settle();
        int n;
        cen = 1'b1;
        ym_busy = 1'b0;
        n = 0;
        while (!(q.size() == 0 && a_src.size() == 0 && b_src.size() == 0 && !m_waiting &&
                 edge_n >= m_ready && !m_a_ack && !m_b_ack) && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL settle_timeout: still busy after %0d cycles, level=%0d", n, level);
        end
        repeat (2) step();
        obs.delete();
        obs_edge.delete();
    endtask

    task automatic test_reset();
        a_src.push_back({2'd0, 8'h3C});
        repeat (3) step();
        checks++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1) begin
            errors++; $display("FAIL reset_strobe: cs_n=%b wr_n=%b want 1 1", ym_cs_n, ym_wr_n);
        end
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b0 || tmo_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: a_ack=%b b_ack=%b tmo_err=%b want 0", a_ack, b_ack, tmo_err);
        end
        checks++;
        if (level !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL reset_level: level=%0d empty=%b full=%b want 0 1 0", level, fifo_empty, fifo_full);
        end
        checks++;
        if (ym_addr !== 2'd0 || ym_din !== 8'h00) begin
            errors++; $display("FAIL reset_bus: addr=%0d din=%h want 0 00", ym_addr, ym_din);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (a_ack !== 1'b1 || level !== 3'd1) begin
            errors++; $display("FAIL first_ack: a_ack=%b level=%0d want 1 1", a_ack, level);
        end
        step();
        checks++;
        if (ym_cs_n !== 1'b0 || ym_wr_n !== 1'b0 || ym_addr !== 2'd0 || ym_din !== 8'h3C) begin
            errors++; $display("FAIL first_write: cs_n=%b wr_n=%b addr=%0d din=%h want 0 0 0 3c",
                               ym_cs_n, ym_wr_n, ym_addr, ym_din);
        end
        step();
        checks++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1 || ym_din !== 8'h3C) begin
            errors++; $display("FAIL strobe_width: cs_n=%b wr_n=%b din=%h want 1 1 3c", ym_cs_n, ym_wr_n, ym_din);
        end
    endtask

    task automatic test_tie();
        settle();
        a_src.push_back({2'd0, 8'h28});
        b_src.push_back({2'd1, 8'hF0});
        step();
        checks++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            errors++; $display("FAIL tie1_first: a_ack=%b b_ack=%b want 1 0", a_ack, b_ack);
        end
        step();
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b1) begin
            errors++; $display("FAIL tie1_second: a_ack=%b b_ack=%b want 0 1", a_ack, b_ack);
        end
        step();
        settle_keep_obs();
        checks++;
        if (obs.size() != 2 || obs[0] !== {2'd0, 8'h28} || obs[1] !== {2'd1, 8'hF0}) begin
            errors++; $display("FAIL tie1_order: got %0d writes first=%h want 2 writes 028,1f0",
                               obs.size(), (obs.size() > 0) ? obs[0] : 10'h0);
        end
        settle();
        a_src.push_back({2'd0, 8'h2A});
        b_src.push_back({2'd1, 8'h0F});
        step();
        checks++;
        if (a_ack !== 1'b0 || b_ack !== 1'b1) begin
            errors++; $display("FAIL tie2_first: a_ack=%b b_ack=%b want 0 1", a_ack, b_ack);
        end
        step();
        checks++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            errors++; $display("FAIL tie2_second: a_ack=%b b_ack=%b want 1 0", a_ack, b_ack);
        end
        settle_keep_obs();
        checks++;
        if (obs.size() != 2 || obs[0] !== {2'd1, 8'h0F} || obs[1] !== {2'd0, 8'h2A}) begin
            errors++; $display("FAIL tie2_order: got %0d writes first=%h want 2 writes 10f,02a",
                               obs.size(), (obs.size() > 0) ? obs[0] : 10'h0);
        end
    endtask

    // Drain without clearing the observed-write log
    task automatic settle_keep_obs();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && a_src.size() == 0 && b_src.size() == 0 && !m_waiting && edge_n >= m_ready)
                break;
            step();
        end
    endtask

    task automatic test_full();
        logic [9:0] exp_list[$];
        bit saw_full;
        settle();
        ym_busy = 1'b1;
        b_src.push_back({2'd1, 8'h90});
        for (int i = 0; i < 5; i++) b_src.push_back({2'($urandom_range(0, 3)), 8'($urandom)});
        exp_list = b_src;
        saw_full = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (fifo_full === 1'b1) saw_full = 1;
            checks++;
            if (level !== LW'(q.size()) || fifo_full !== (q.size() == DEPTH) || b_ack !== m_b_ack) begin
                errors++; $display("FAIL full_track: level=%0d full=%b b_ack=%b want %0d %b %b",
                                   level, fifo_full, b_ack, q.size(), q.size() == DEPTH, m_b_ack);
            end
        end
        checks++;
        if (!saw_full || level !== 3'd4 || b_ack !== 1'b0 || b_req !== 1'b1) begin
            errors++; $display("FAIL full_hold: saw_full=%b level=%0d b_ack=%b b_req=%b want 1 4 0 1",
                               saw_full, level, b_ack, b_req);
        end
        ym_busy = 1'b0;
        settle_keep_obs();
        repeat (3) step();
        checks++;
        if (obs.size() != 6) begin
            errors++; $display("FAIL full_count: got %0d writes want 6", obs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs[i] !== exp_list[i]) begin
                    errors++; $display("FAIL full_order[%0d]: got %h want %h", i, obs[i], exp_list[i]);
                end
            end
        end
    endtask

    task automatic test_spacing();
        int s;
        settle();
        ym_busy = 1'b1;
        a_src.push_back({2'd1, 8'h55});
        a_src.push_back({2'd0, 8'h11});
        a_src.push_back({2'd0, 8'h22});
        a_src.push_back({2'd0, 8'h33});
        for (int i = 0; i < 200 && obs.size() < 4; i++) begin
            if (obs.size() > 0) ym_busy = (edge_n < obs_edge[0] + 10);
            step();
        end
        checks++;
        if (obs.size() < 4) begin
            errors++; $display("FAIL spacing_timeout: got %0d writes want 4", obs.size());
        end else begin
            s = obs_edge[0];
            checks++;
            if (obs[0] !== {2'd1, 8'h55} || obs_edge[1] != s + 12) begin
                errors++; $display("FAIL busy_gap: first=%h second strobe at +%0d want 155 at +12",
                                   obs[0], obs_edge[1] - s);
            end
            checks++;
            if (obs_edge[2] - obs_edge[1] != 2 || obs_edge[3] - obs_edge[2] != 2) begin
                errors++; $display("FAIL addr_spacing: gaps %0d %0d want 2 2",
                                   obs_edge[2] - obs_edge[1], obs_edge[3] - obs_edge[2]);
            end
            checks++;
            if (obs[1] !== {2'd0, 8'h11} || obs[2] !== {2'd0, 8'h22} || obs[3] !== {2'd0, 8'h33}) begin
                errors++; $display("FAIL addr_order: got %h %h %h want 011 022 033", obs[1], obs[2], obs[3]);
            end
        end
        ym_busy = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses, tmo_edge;
        settle();
        ym_busy = 1'b1;
        a_src.push_back({2'd1, 8'hA5});
        a_src.push_back({2'd0, 8'h07});
        pulses = 0;
        tmo_edge = -1;
        for (int i = 0; i < 400 && obs.size() < 2; i++) begin
            step();
            checks++;
            if (tmo_err !== exp_tmo) begin
                errors++; $display("FAIL tmo_track: tmo_err=%b want %b at edge %0d", tmo_err, exp_tmo, edge_n);
            end
            if (tmo_err === 1'b1) begin pulses++; tmo_edge = edge_n; end
        end
        checks++;
        if (obs.size() != 2 || pulses != 1) begin
            errors++; $display("FAIL tmo_count: writes=%0d pulses=%0d want 2 1", obs.size(), pulses);
        end else begin
            checks++;
            if (tmo_edge != obs_edge[0] + 1 + GAP + TMO || obs_edge[1] != tmo_edge + 1 || obs[1] !== {2'd0, 8'h07}) begin
                errors++; $display("FAIL tmo_timing: pulse at +%0d next write at +%0d (%h) want +%0d +%0d (007)",
                                   tmo_edge - obs_edge[0], obs_edge[1] - obs_edge[0], obs[1],
                                   1 + GAP + TMO, 2 + GAP + TMO);
            end
        end
        ym_busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        settle();
        cen = 1'b0;
        a_src.push_back({2'd1, 8'h61});
        a_src.push_back({2'd3, 8'h62});
        b_src.push_back({2'd1, 8'h63});
        b_src.push_back({2'd3, 8'h64});
        for (int i = 0; i < 20 && q.size() < 4; i++) step();
        checks++;
        if (level !== 3'd4 || fifo_full !== 1'b1 || ym_cs_n !== 1'b1) begin
            errors++; $display("FAIL cen_stall: level=%0d full=%b cs_n=%b want 4 1 1", level, fifo_full, ym_cs_n);
        end
        cen = 1'b1;
        step();
        step();
        checks++;
        if (level !== 3'd3) begin
            errors++; $display("FAIL mid_level_pre: level=%0d want 3", level);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        a_src.delete();
        b_src.delete();
        #1;
        checks++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1 || level !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async: cs_n=%b wr_n=%b level=%0d empty=%b full=%b want 1 1 0 1 0",
                               ym_cs_n, ym_wr_n, level, fifo_empty, fifo_full);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (ym_cs_n !== 1'b1 || level !== 3'd0) begin
                errors++; $display("FAIL mid_no_write: cs_n=%b level=%0d want 1 0", ym_cs_n, level);
            end
        end
        // Reset landing while the strobe is low must release it at once
        a_src.push_back({2'd0, 8'h70});
        for (int i = 0; i < 10 && ym_cs_n !== 1'b0; i++) step();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1 || ym_din !== 8'h00) begin
            errors++; $display("FAIL strobe_async_release: cs_n=%b wr_n=%b din=%h want 1 1 00", ym_cs_n, ym_wr_n, ym_din);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        settle();
        for (int i = 0; i < 900; i++) begin
            if (a_src.size() == 0 && $urandom_range(0, 2) == 0)
                a_src.push_back({2'($urandom_range(0, 3)), 8'($urandom)});
            if (b_src.size() == 0 && $urandom_range(0, 2) == 0)
                b_src.push_back({2'($urandom_range(0, 3)), 8'($urandom)});
            cen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) ym_busy = ~ym_busy;
            step();
            checks++;
            if (a_ack !== m_a_ack || b_ack !== m_b_ack) begin
                errors++; $display("FAIL rand_ack: a=%b b=%b want %b %b at edge %0d", a_ack, b_ack, m_a_ack, m_b_ack, edge_n);
            end
            checks++;
            if (ym_cs_n !== exp_cs || ym_wr_n !== exp_cs) begin
                errors++; $display("FAIL rand_strobe: cs_n=%b wr_n=%b want %b at edge %0d", ym_cs_n, ym_wr_n, exp_cs, edge_n);
            end
            checks++;
            if (ym_addr !== exp_addr || ym_din !== exp_din) begin
                errors++; $display("FAIL rand_data: addr=%0d din=%h want %0d %h at edge %0d", ym_addr, ym_din, exp_addr, exp_din, edge_n);
            end
            checks++;
            if (level !== LW'(q.size()) || fifo_full !== (q.size() == DEPTH) || fifo_empty !== (q.size() == 0)) begin
                errors++; $display("FAIL rand_level: level=%0d full=%b empty=%b want %0d at edge %0d",
                                   level, fifo_full, fifo_empty, q.size(), edge_n);
            end
            checks++;
            if (tmo_err !== exp_tmo) begin
                errors++; $display("FAIL rand_tmo: tmo_err=%b want %b at edge %0d", tmo_err, exp_tmo, edge_n);
            end
        end
        settle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_tie();
        test_full();
        test_spacing();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
